slice_pass_ctrl: RTL and testbench

Sequencer for one 25-bit slice memory block in the 5x5 slice datapath. On `start` it loads a slice, then walks all 25 indices in ascending order. At each index it reads the stored bit and writes back that bit XOR a per-index key bit, which makes one mask pass over the slice. It owns every control port of the memory block, returns the final slice contents, and counts the bits written as 1.

---
 rtl/slice_pass_ctrl.sv | 109 ++++++++++
 tb/tb_slice_pass_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/slice_pass_ctrl.sv
// Mask-pass sequencer for one 25-bit slice memory: load, then read/XOR-write every index.
// Also returns the final slice and the number of bits written as 1.
module slice_pass_ctrl #(
    parameter int SIZE    = 5,
    parameter int MEMSIZE = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MEMSIZE-1:0] in_line,
    input  logic [MEMSIZE-1:0] key,
    output logic               busy,
    output logic               done,
    output logic [MEMSIZE-1:0] result,
    output logic [SIZE-1:0]    ones_cnt,
    output logic               mem_init,
    output logic [MEMSIZE-1:0] mem_line,
    output logic [SIZE-1:0]    mem_index,
    output logic               mem_val,
    output logic               mem_write,
    output logic               mem_read,
    input  logic               mem_out,
    input  logic [MEMSIZE-1:0] mem_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(MEMSIZE - 1);

    state_t             r_state;
    state_t             w_next;
    logic [MEMSIZE-1:0] r_line;
    logic [MEMSIZE-1:0] r_key;
    logic [SIZE-1:0]    r_idx;
    logic [SIZE-1:0]    r_acc;
    logic               r_bit;
    logic [MEMSIZE-1:0] r_result;
    logic [SIZE-1:0]    r_ones;
    logic               w_val;

    assign w_val = r_bit ^ r_key[r_idx];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = (r_idx == LAST_IDX) ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_line   <= '0;
            r_key    <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_bit    <= 1'b0;
            r_result <= '0;
            r_ones   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_line <= in_line;
                        r_key  <= key;
                        r_idx  <= '0;
                        r_acc  <= '0;
                    end
                end
                S_READ: r_bit <= mem_out;
                S_WRITE: begin
                    if (w_val) r_acc <= r_acc + SIZE'(1);
                    // idx holds at the last index so it never leaves 0..MEMSIZE-1
                    if (r_idx != LAST_IDX) r_idx <= r_idx + SIZE'(1);
                end
                S_DONE: begin
                    r_result <= mem_q;
                    r_ones   <= r_acc;
                end
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state only; start never reaches mem_* directly.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mem_init  = (r_state == S_LOAD);
    assign mem_read  = (r_state == S_READ) || (r_state == S_WRITE);
    assign mem_write = (r_state == S_WRITE);
    assign mem_val   = (r_state == S_WRITE) ? w_val : 1'b0;
    assign mem_index = mem_read ? r_idx : '0;
    assign mem_line  = r_line;
    assign result    = r_result;
    assign ones_cnt  = r_ones;

endmodule

// File: tb/tb_slice_pass_ctrl.sv
// Bench for slice_pass_ctrl: ideal slice memory, directed passes, scoreboard-checked
// done timing, result, ones count and strobe sequencing.
module tb_slice_pass_ctrl;

    localparam int SIZE    = 5;
    localparam int MEMSIZE = 25;
    localparam int W       = MEMSIZE + SIZE;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [MEMSIZE-1:0] in_line = '0;
    logic [MEMSIZE-1:0] key = '0;
    logic               busy, done, mem_init, mem_val, mem_write, mem_read, mem_out;
    logic [MEMSIZE-1:0] result, mem_line, mem_q;
    logic [SIZE-1:0]    ones_cnt, mem_index;

    logic [MEMSIZE-1:0] tb_mem = '0;

    slice_pass_ctrl #(.SIZE(SIZE), .MEMSIZE(MEMSIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_line   (in_line),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ones_cnt  (ones_cnt),
        .mem_init  (mem_init),
        .mem_line  (mem_line),
        .mem_index (mem_index),
        .mem_val   (mem_val),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_out   (mem_out),
        .mem_q     (mem_q)
    );

    // clock / reset block and ideal memory
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) tb_mem <= mem_line;
        else if (mem_write) tb_mem[mem_index] <= mem_val;
    end
    assign mem_out = mem_read ? tb_mem[mem_index] : 1'b0;
    assign mem_q   = tb_mem;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int           exp_t_q[$];
    int           checks = 0;
    int           errors = 0;
    bit           res_pending = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: strobe sequencing and done/result comparison
    int             n_init = 0, n_write = 0, seq_err = 0, exp_widx = 0;
    bit             rd_seen = 0;
    logic [SIZE-1:0] last_ridx = '0;

    task automatic clear_seq();
        n_init = 0; n_write = 0; seq_err = 0; exp_widx = 0; rd_seen = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            clear_seq();
            res_pending = 0;
        end else begin
            if (mem_init) n_init++;
            if (mem_init && (mem_read || mem_write)) seq_err++;
            if (mem_write) begin
                n_write++;
                if (!mem_read || !rd_seen || last_ridx != mem_index ||
                    mem_index != SIZE'(exp_widx)) seq_err++;
                exp_widx++;
                rd_seen = 0;
            end else if (mem_read) begin
                rd_seen   = 1;
                last_ridx = mem_index;
            end
            if (res_pending) begin
                res_pending = 0;
                if (exp_q.size() > 0) check("result_ones", 32'({result, ones_cnt}), 32'(exp_q.pop_front()));
            end
            if (done) begin
                if (exp_t_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    check("done_cycle", cyc, exp_t_q.pop_front());
                    check("init_count", n_init, 1);
                    check("write_count", n_write, MEMSIZE);
                    check("seq_errors", seq_err, 0);
                    res_pending = 1;
                end
                clear_seq();
            end
        end
    end

    // driver tasks (inputs change 1 time unit after posedge)
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input logic [MEMSIZE-1:0] l, input logic [MEMSIZE-1:0] k,
                            input logic [MEMSIZE-1:0] er, input logic [SIZE-1:0] eo);
        in_line = l;
        key     = k;
        start   = 1'b1;
        exp_t_q.push_back(cyc + 52);
        exp_q.push_back({er, eo});
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while ((exp_t_q.size() > 0 || exp_q.size() > 0 || res_pending) && n < max_cyc) begin
            step(1);
            n++;
        end
        if (exp_t_q.size() > 0 || exp_q.size() > 0) begin
            check("timeout_pending", 32'(exp_t_q.size() + exp_q.size()), 32'(0));
            exp_t_q.delete();
            exp_q.delete();
        end
        step(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({busy, done, mem_init, mem_val, mem_write, mem_read, mem_index, ones_cnt}), 32'(0));
        check({tag, "_result"}, 32'(result), 32'(0));
        check({tag, "_line"}, 32'(mem_line), 32'(0));
    endtask

    initial begin
        rst = 1'b0;
        step(3);
        check_reset_outputs("por");
        rst = 1'b1;
        step(2);

        // zero key: slice comes back unchanged
        run_pass(25'h1ABCDEF, 25'h0000000, 25'h1ABCDEF, 5'd18);
        wait_drain(100);

        // full invert of an all-zero slice
        run_pass(25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF, 5'd25);
        wait_drain(100);

        // reset mid-pass: pass abandoned, no done, outputs cleared
        run_pass(25'h1555555, 25'h0AAAAAA, 25'h1FFFFFF, 5'd25);
        step(20);
        rst = 1'b0;
        exp_t_q.delete();
        exp_q.delete();
        step(1);
        check_reset_outputs("midpass_reset");
        step(2);
        check_reset_outputs("held_reset");
        rst = 1'b1;
        step(60);
        check("idle_after_reset", 32'({busy, done}), 32'(0));

        // start while busy is ignored
        run_pass(25'h0F0F0F0, 25'h0000FFF, 25'h0F0FF0F, 5'd16);
        step(9);
        in_line = 25'h1FFFFFF;
        key     = 25'h1FFFFFF;
        start   = 1'b1;
        step(3);
        start = 1'b0;
        wait_drain(100);
        step(60);

        // back-to-back with start held: second pass re-masks the first result
        in_line = 25'h1234567;
        key     = 25'h0155555;
        start   = 1'b1;
        exp_t_q.push_back(cyc + 52);
        exp_t_q.push_back(cyc + 53 + 52);
        exp_q.push_back({25'h1361032, 5'd9});
        exp_q.push_back({25'h1234567, 5'd12});
        step(1);
        in_line = 25'h1361032;
        step(60);
        start = 1'b0;
        wait_drain(120);
        step(60);

        check("queue_empty", 32'(exp_q.size() + exp_t_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
